// File: rtl/tick_arbiter.sv
// Round-robin arbiter for one-clock request ticks.
// It latches the ticks as pending bits, flags overruns, and offers one registered grant at a time.
module tick_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  input  logic           grant_ack,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overrun,
  input  logic           clear_overrun
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic           grant_valid_q, grant_valid_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_id_q, last_id_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   overrun_q, overrun_d;

  logic [N-1:0]   clr_mask;
  logic           acked;
  logic           sel_found;
  logic [IDW-1:0] sel_id;
  logic [IDW:0]   idx;
  logic [IDW-1:0] idx_s;

  // Round-robin search: first pending index after last_id, with wrap
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = '0;
    idx_s     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = {1'b0, last_id_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N)) begin
        idx = idx - (IDW+1)'(N);
      end
      idx_s = idx[IDW-1:0];
      if (!sel_found && pending_q[idx_s]) begin
        sel_found = 1'b1;
        sel_id    = idx_s;
      end
    end
  end

  assign acked    = (state_q == GRANT) && grant_ack;
  assign clr_mask = acked ? (N'(1) << grant_id_q) : '0;

  // A tick on the bit being serviced this cycle re-arms it cleanly
  always_comb begin
    pending_d = (pending_q & ~clr_mask) | req;
    overrun_d = clear_overrun ? '0 : overrun_q;
    overrun_d = overrun_d | (req & pending_q & ~clr_mask);
  end

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    last_id_d     = last_id_q;
    unique case (state_q)
      IDLE: begin
        grant_valid_d = 1'b0;
        if (sel_found) begin
          state_d       = GRANT;
          grant_valid_d = 1'b1;
          grant_id_d    = sel_id;
        end
      end
      GRANT: begin
        if (grant_ack) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
          last_id_d     = grant_id_q;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_id_q     <= IDW'(N-1);
      pending_q     <= '0;
      overrun_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      last_id_q     <= last_id_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign pending     = pending_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_tick_arbiter.sv
// Bench for tick_arbiter: directed scenarios plus a randomized run
// against a behavioural model.
module tb_tick_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           grant_ack;
  logic [N-1:0]   pending;
  logic [N-1:0]   overrun;
  logic           clear_overrun;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] m_pend, m_ovr;
  logic         m_gv;
  int           m_gid, m_last;

  tick_arbiter #(.N(N), .IDW(IDW)) dut (
    .clock(clock), .reset(reset), .req(req),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .grant_ack(grant_ack), .pending(pending),
    .overrun(overrun), .clear_overrun(clear_overrun)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, advance the model, sample 1 ns after the edge
  task automatic step(input logic [N-1:0] r, input logic a,
                      input logic c, input logic rs);
    logic [N-1:0] np, no;
    int cl, k;
    req = r; grant_ack = a; clear_overrun = c; reset = rs;
    @(posedge clock);
    if (rs) begin
      m_pend = '0; m_ovr = '0; m_gv = 1'b0; m_gid = 0; m_last = N-1;
    end else begin
      cl = (m_gv && a) ? m_gid : -1;
      np = m_pend;
      if (cl >= 0) np[cl] = 1'b0;
      no = c ? '0 : m_ovr;
      for (int i = 0; i < N; i++) if (r[i] && np[i]) no[i] = 1'b1;
      np = np | r;
      if (m_gv) begin
        if (a) begin m_gv = 1'b0; m_last = m_gid; end
      end else if (m_pend != '0) begin
        k = m_last;
        do k = (k + 1) % N; while (!m_pend[k]);
        m_gid = k; m_gv = 1'b1;
      end
      m_pend = np; m_ovr = no;
    end
    #1;
  endtask

  task automatic test_reset();
    step('0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({grant_valid, grant_id, pending, overrun} !== '0) begin
      errors++;
      $display("FAIL reset: gv=%b id=%0d pend=%b ovr=%b want all 0",
               grant_valid, grant_id, pending, overrun);
    end
  endtask

  task automatic test_single();
    step('0, 1'b0, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pending !== 4'b0001 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_c1: pend=%b gv=%b want 0001 0", pending, grant_valid);
    end
    step('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL single_c2: gv=%b id=%0d want 1 0", grant_valid, grant_id);
    end
    step('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL single_hold: gv=%b id=%0d want 1 0", grant_valid, grant_id);
    end
    step('0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pending !== 4'b0000 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: pend=%b gv=%b want 0000 0", pending, grant_valid);
    end
  endtask

  task automatic test_back_to_back();
    step('0, 1'b0, 1'b0, 1'b1);
    step(4'b1111, 1'b1, 1'b0, 1'b0);
    for (int g = 0; g < N; g++) begin
      step('0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== IDW'(g)) begin
        errors++;
        $display("FAIL b2b_grant%0d: gv=%b id=%0d want 1 %0d",
                 g, grant_valid, grant_id, g);
      end
      step('0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (grant_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_gap%0d: gv=%b want 0", g, grant_valid);
      end
    end
    checks++;
    if (pending !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_drain: pend=%b want 0000", pending);
    end
  endtask

  task automatic test_wrap();
    step('0, 1'b0, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL wrap_other_tick: gv=%b id=%0d want 1 2", grant_valid, grant_id);
    end
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pending !== 4'b0101 || overrun !== 4'b0000 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ack: pend=%b ovr=%b gv=%b want 0101 0000 0",
               pending, overrun, grant_valid);
    end
    step('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL wrap_first: gv=%b id=%0d want 1 0", grant_valid, grant_id);
    end
    step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL wrap_second: gv=%b id=%0d want 1 2", grant_valid, grant_id);
    end
  endtask

  task automatic test_overrun();
    int ngrants;
    step('0, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0, 1'b0);
    checks++;
    if (overrun !== 4'b0010 || pending !== 4'b0010) begin
      errors++;
      $display("FAIL ovr_set: ovr=%b pend=%b want 0010 0010", overrun, pending);
    end
    step(4'b0010, 1'b0, 1'b1, 1'b0);
    checks++;
    if (overrun !== 4'b0010) begin
      errors++;
      $display("FAIL ovr_clear_race: ovr=%b want 0010", overrun);
    end
    step('0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (overrun !== 4'b0000) begin
      errors++;
      $display("FAIL ovr_clear: ovr=%b want 0000", overrun);
    end
    ngrants = 0;
    for (int c = 0; c < 8; c++) begin
      if (grant_valid === 1'b1) ngrants++;
      step('0, grant_valid, 1'b0, 1'b0);
    end
    checks++;
    if (ngrants != 1 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL ovr_one_grant: grants=%0d pend=%b want 1 0000", ngrants, pending);
    end
  endtask

  task automatic test_coincident();
    step('0, 1'b0, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    step(4'b1000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pending !== 4'b1000 || overrun !== 4'b0000 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL coin_ack: pend=%b ovr=%b gv=%b want 1000 0000 0",
               pending, overrun, grant_valid);
    end
    step('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd3) begin
      errors++;
      $display("FAIL coin_regrant: gv=%b id=%0d want 1 3", grant_valid, grant_id);
    end
  endtask

  task automatic test_reset_mid_grant();
    step('0, 1'b0, 1'b0, 1'b1);
    step(4'b1010, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    step(4'b0101, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({grant_valid, grant_id, pending, overrun} !== '0) begin
      errors++;
      $display("FAIL midrst: gv=%b id=%0d pend=%b ovr=%b want all 0",
               grant_valid, grant_id, pending, overrun);
    end
    step(4'b0010, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL midrst_regrant: gv=%b id=%0d want 1 1", grant_valid, grant_id);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    step('0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 3) == 0);
      step(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 59) == 0));
      checks++;
      if (pending !== m_pend || overrun !== m_ovr || grant_valid !== m_gv ||
          (m_gv && grant_id !== IDW'(m_gid))) begin
        errors++;
        $display("FAIL rand_c%0d: pend=%b ovr=%b gv=%b id=%0d want %b %b %b %0d",
                 c, pending, overrun, grant_valid, grant_id,
                 m_pend, m_ovr, m_gv, m_gid);
      end
    end
  endtask

  initial begin
    req = '0; grant_ack = 1'b0; clear_overrun = 1'b0; reset = 1'b1;
    m_pend = '0; m_ovr = '0; m_gv = 1'b0; m_gid = 0; m_last = N-1;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_overrun();
    test_coincident();
    test_reset_mid_grant();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
